// File: rtl/id_scoreboard_if.sv
// IF/ID -> ID/EX handshake, register-file read and forwarding bus for id_scoreboard.
interface id_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NFWD = 2
);
  logic                 in_valid;
  logic [31:0]          in_inst;
  logic                 in_ready;
  logic                 flush;
  logic [4:0]           raddr1;
  logic [4:0]           raddr2;
  logic [XLEN-1:0]      rdata1;
  logic [XLEN-1:0]      rdata2;
  logic [NFWD-1:0]      fw_we;
  logic [5*NFWD-1:0]    fw_addr;
  logic [XLEN*NFWD-1:0] fw_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           out_class;
  logic [2:0]           out_funct3;
  logic [6:0]           out_funct7;
  logic [4:0]           out_rd;
  logic                 out_wreg;
  logic [XLEN-1:0]      out_opa;
  logic [XLEN-1:0]      out_opb;
  logic [XLEN-1:0]      out_storedata;

  modport slave (
    input  in_valid, in_inst, flush, rdata1, rdata2, fw_we, fw_addr, fw_data, out_ready,
    output in_ready, raddr1, raddr2, out_valid, out_class, out_funct3, out_funct7,
           out_rd, out_wreg, out_opa, out_opb, out_storedata
  );
  modport master (
    output in_valid, in_inst, flush, rdata1, rdata2, fw_we, fw_addr, fw_data, out_ready,
    input  in_ready, raddr1, raddr2, out_valid, out_class, out_funct3, out_funct7,
           out_rd, out_wreg, out_opa, out_opb, out_storedata
  );
endinterface

// File: rtl/id_scoreboard.sv
// RV32 decode stage with operand forwarding and a per-register load-latency scoreboard
// that stalls load-use dependents until the load result reaches a forwarding source.
module id_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NFWD     = 2,
  parameter int LOAD_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  id_scoreboard_if.slave sb
);
  localparam logic [2:0] C_NOP = 3'd0, C_ALUI = 3'd1, C_ALUR = 3'd2, C_LOAD = 3'd3, C_STORE = 3'd4;
  localparam int         CW    = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(LOAD_LAT);

  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [2:0]      w_class;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_src1, w_src2;
  logic [XLEN-1:0] w_opa, w_opb, w_sd;
  logic            w_wreg, w_use1, w_use2, w_hazard, w_issue, w_ld;

  logic [CW-1:0]   r_cnt [32];
  logic            r_valid, r_wreg;
  logic [2:0]      r_class, r_funct3;
  logic [6:0]      r_funct7;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_opa, r_opb, r_sd;

  assign w_rs1 = sb.in_inst[19:15];
  assign w_rs2 = sb.in_inst[24:20];
  assign w_rd  = sb.in_inst[11:7];
  assign sb.raddr1 = w_rs1;
  assign sb.raddr2 = w_rs2;

  assign w_imm_i = {{(XLEN-12){sb.in_inst[31]}}, sb.in_inst[31:20]};
  assign w_imm_s = {{(XLEN-12){sb.in_inst[31]}}, sb.in_inst[31:25], sb.in_inst[11:7]};

  always_comb begin
    case (sb.in_inst[6:0])
      7'b0010011: w_class = C_ALUI;
      7'b0110011: w_class = C_ALUR;
      7'b0000011: w_class = C_LOAD;
      7'b0100011: w_class = C_STORE;
      default:    w_class = C_NOP;
    endcase
  end

  // Walk sources oldest to youngest so the lowest index ends up winning.
  always_comb begin
    w_src1 = sb.rdata1;
    w_src2 = sb.rdata2;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (sb.fw_we[k] && sb.fw_addr[5*k +: 5] == w_rs1) w_src1 = sb.fw_data[XLEN*k +: XLEN];
      if (sb.fw_we[k] && sb.fw_addr[5*k +: 5] == w_rs2) w_src2 = sb.fw_data[XLEN*k +: XLEN];
    end
    if (w_rs1 == 5'd0) w_src1 = '0;
    if (w_rs2 == 5'd0) w_src2 = '0;
  end

  always_comb begin
    w_opa = '0;
    w_opb = '0;
    w_sd  = '0;
    case (w_class)
      C_ALUI, C_LOAD: begin w_opa = w_src1; w_opb = w_imm_i; end
      C_ALUR:         begin w_opa = w_src1; w_opb = w_src2;  end
      C_STORE:        begin w_opa = w_src1; w_opb = w_imm_s; w_sd = w_src2; end
      default:        ;
    endcase
  end

  assign w_wreg   = (w_class == C_ALUI || w_class == C_ALUR || w_class == C_LOAD) && w_rd != 5'd0;
  assign w_use1   = w_class != C_NOP;
  assign w_use2   = w_class == C_ALUR || w_class == C_STORE;
  assign w_hazard = sb.in_valid &&
                    ((w_use1 && w_rs1 != 5'd0 && r_cnt[w_rs1] != '0) ||
                     (w_use2 && w_rs2 != 5'd0 && r_cnt[w_rs2] != '0));
  assign sb.in_ready = !rst && !w_hazard && (!r_valid || sb.out_ready) && !sb.flush;
  assign w_issue  = sb.in_valid && sb.in_ready;
  assign w_ld     = w_issue && w_class == C_LOAD && w_rd != 5'd0;

  // Flush leaves the counters alone: a flushed load is still in flight in EX/MEM.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      if (rst || r == 0)               r_cnt[r] <= '0;
      else if (w_ld && w_rd == 5'(r))  r_cnt[r] <= LAT;
      else if (r_cnt[r] != '0)         r_cnt[r] <= r_cnt[r] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_class  <= C_NOP;
      r_funct3 <= '0;
      r_funct7 <= '0;
      r_rd     <= '0;
      r_wreg   <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_sd     <= '0;
    end else if (sb.flush) begin
      r_valid  <= 1'b0;
    end else if (w_issue) begin
      r_valid  <= 1'b1;
      r_class  <= w_class;
      r_funct3 <= sb.in_inst[14:12];
      r_funct7 <= sb.in_inst[31:25];
      r_rd     <= w_rd;
      r_wreg   <= w_wreg;
      r_opa    <= w_opa;
      r_opb    <= w_opb;
      r_sd     <= w_sd;
    end else if (sb.out_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign sb.out_valid     = r_valid;
  assign sb.out_class     = r_class;
  assign sb.out_funct3    = r_funct3;
  assign sb.out_funct7    = r_funct7;
  assign sb.out_rd        = r_rd;
  assign sb.out_wreg      = r_wreg;
  assign sb.out_opa       = r_opa;
  assign sb.out_opb       = r_opb;
  assign sb.out_storedata = r_sd;
endmodule

// File: tb/tb_id_scoreboard.sv
// Directed and randomized checks of id_scoreboard against a cycle-counting reference model.
module tb_id_scoreboard;
  localparam int XLEN = 32, NFWD = 2, LOAD_LAT = 2;

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        wreg;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] sd;
  } slot_t;

  logic clk, rst;
  id_scoreboard_if #(.XLEN(XLEN), .NFWD(NFWD)) bus();
  id_scoreboard #(.XLEN(XLEN), .NFWD(NFWD), .LOAD_LAT(LOAD_LAT)) dut (.clk(clk), .rst(rst), .sb(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_chk = 0, n_fail = 0;
  int    cyc = 0;
  int    busy_until [32];  // last cycle in which a reader of r must still wait
  bit    m_valid = 0;
  slot_t m_slot = '0;

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [11:0] im = imm[11:0];
    return {im, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [11:0] im = imm[11:0];
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] m_src(int r, logic [31:0] rdv);
    if (r == 0) return 32'd0;
    for (int k = 0; k < NFWD; k++)
      if (bus.fw_we[k] && int'(bus.fw_addr[5*k +: 5]) == r) return bus.fw_data[32*k +: 32];
    return rdv;
  endfunction

  function automatic slot_t m_decode();
    slot_t s;
    logic [31:0] in = bus.in_inst;
    int ii, is;
    int rs1 = int'(in[19:15]), rs2 = int'(in[24:20]);
    ii = $signed(in[31:20]);
    is = $signed({in[31:25], in[11:7]});
    s = '0;
    case (in[6:0])
      7'h13: s.cls = 3'd1;
      7'h33: s.cls = 3'd2;
      7'h03: s.cls = 3'd3;
      7'h23: s.cls = 3'd4;
      default: s.cls = 3'd0;
    endcase
    s.f3 = in[14:12];
    s.f7 = in[31:25];
    s.rd = in[11:7];
    s.wreg = (s.cls inside {3'd1, 3'd2, 3'd3}) && s.rd != 0;
    if (s.cls != 0) s.opa = m_src(rs1, bus.rdata1);
    if (s.cls == 1 || s.cls == 3) s.opb = ii;
    if (s.cls == 2) s.opb = m_src(rs2, bus.rdata2);
    if (s.cls == 4) begin s.opb = is; s.sd = m_src(rs2, bus.rdata2); end
    return s;
  endfunction

  function automatic bit m_ready();
    slot_t d = m_decode();
    int rs1 = int'(bus.in_inst[19:15]), rs2 = int'(bus.in_inst[24:20]);
    bit hz = 0;
    if (bus.in_valid) begin
      if (d.cls != 0 && rs1 != 0 && cyc <= busy_until[rs1]) hz = 1;
      if ((d.cls == 2 || d.cls == 4) && rs2 != 0 && cyc <= busy_until[rs2]) hz = 1;
    end
    return !rst && !hz && (!m_valid || bus.out_ready) && !bus.flush;
  endfunction

  // Advance model and clock together; returns #1 after the rising edge.
  task automatic tick();
    slot_t d = m_decode();
    bit iss = bus.in_valid && m_ready();
    if (rst) begin
      m_valid = 0; m_slot = '0;
      foreach (busy_until[i]) busy_until[i] = -1;
    end else if (bus.flush) m_valid = 0;
    else if (iss) begin
      m_valid = 1; m_slot = d;
      if (d.cls == 3 && d.rd != 0) busy_until[d.rd] = cyc + LOAD_LAT;
    end else if (bus.out_ready) m_valid = 0;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.flush = 0; bus.fw_we = '0; bus.fw_addr = '0; bus.fw_data = '0;
    bus.out_ready = 1; bus.rdata1 = '0; bus.rdata2 = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    bus.in_valid = 1; bus.in_inst = 32'h00500093;
    tick(); tick();
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0h want 0", bus.in_ready); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0h want 0", bus.out_valid); end
    n_chk++; if ({bus.out_class, bus.out_wreg, bus.out_rd, bus.out_funct3, bus.out_funct7} !== 19'd0) begin
      n_fail++; $display("FAIL reset_fields got %0h want 0", {bus.out_class, bus.out_wreg, bus.out_rd, bus.out_funct3, bus.out_funct7}); end
    n_chk++; if ({bus.out_opa, bus.out_opb, bus.out_storedata} !== 96'd0) begin
      n_fail++; $display("FAIL reset_data got %0h want 0", {bus.out_opa, bus.out_opb, bus.out_storedata}); end
    rst = 0; idle();
    tick();
  endtask

  task automatic test_addi();
    idle(); bus.in_valid = 1; bus.in_inst = 32'h00500093; bus.rdata1 = 32'h123;
    #1;
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready got %0h want 1", bus.in_ready); end
    n_chk++; if ({bus.raddr1, bus.raddr2} !== {5'd0, 5'd5}) begin n_fail++; $display("FAIL addi_raddr got %0h want %0h", {bus.raddr1, bus.raddr2}, {5'd0, 5'd5}); end
    tick(); idle();
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %0h want 1", bus.out_valid); end
    n_chk++; if ({bus.out_class, bus.out_rd, bus.out_wreg} !== {3'd1, 5'd1, 1'b1}) begin
      n_fail++; $display("FAIL addi_fields got %0h want %0h", {bus.out_class, bus.out_rd, bus.out_wreg}, {3'd1, 5'd1, 1'b1}); end
    n_chk++; if ({bus.out_opa, bus.out_opb} !== {32'd0, 32'd5}) begin
      n_fail++; $display("FAIL addi_ops got %0h want %0h", {bus.out_opa, bus.out_opb}, {32'd0, 32'd5}); end
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got %0h want 0", bus.out_valid); end
  endtask

  task automatic test_forward_priority();
    idle(); bus.in_valid = 1; bus.in_inst = enc_r(0, 2, 1, 0, 3);
    bus.fw_we = 2'b11; bus.fw_addr = {5'd1, 5'd1}; bus.fw_data = {32'hB, 32'hA};
    bus.rdata1 = 32'h99; bus.rdata2 = 32'h7;
    tick(); idle();
    n_chk++; if ({bus.out_class, bus.out_rd, bus.out_wreg} !== {3'd2, 5'd3, 1'b1}) begin
      n_fail++; $display("FAIL fwd_fields got %0h want %0h", {bus.out_class, bus.out_rd, bus.out_wreg}, {3'd2, 5'd3, 1'b1}); end
    n_chk++; if ({bus.out_opa, bus.out_opb} !== {32'hA, 32'h7}) begin
      n_fail++; $display("FAIL fwd_ops got %0h want %0h", {bus.out_opa, bus.out_opb}, {32'hA, 32'h7}); end
  endtask

  task automatic test_load_use();
    idle(); bus.in_valid = 1; bus.in_inst = enc_i(0, 4, 2, 5, 7'h03); bus.rdata1 = 32'h200;
    tick();
    n_chk++; if ({bus.out_class, bus.out_rd, bus.out_wreg, bus.out_opa, bus.out_opb} !== {3'd3, 5'd5, 1'b1, 32'h200, 32'h0}) begin
      n_fail++; $display("FAIL lw_slot got %0h want %0h", {bus.out_class, bus.out_rd, bus.out_wreg, bus.out_opa, bus.out_opb}, {3'd3, 5'd5, 1'b1, 32'h200, 32'h0}); end
    bus.in_inst = enc_r(0, 5, 5, 0, 6); bus.rdata1 = 32'h1; bus.rdata2 = 32'h2;
    for (int i = 0; i < LOAD_LAT; i++) begin
      #1;
      n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall%0d got %0h want 0", i, bus.in_ready); end
      tick();
    end
    bus.fw_we = 2'b01; bus.fw_addr = {5'd0, 5'd5}; bus.fw_data = {32'h0, 32'hDEAD};
    #1;
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_release got %0h want 1", bus.in_ready); end
    tick(); idle();
    n_chk++; if ({bus.out_valid, bus.out_class, bus.out_opa, bus.out_opb} !== {1'b1, 3'd2, 32'hDEAD, 32'hDEAD}) begin
      n_fail++; $display("FAIL lu_add got %0h want %0h", {bus.out_valid, bus.out_class, bus.out_opa, bus.out_opb}, {1'b1, 3'd2, 32'hDEAD, 32'hDEAD}); end
  endtask

  task automatic test_store();
    idle(); bus.in_valid = 1; bus.in_inst = enc_s(-4, 7, 8, 2); bus.rdata1 = 32'h100; bus.rdata2 = 32'h55;
    tick(); idle();
    n_chk++; if ({bus.out_class, bus.out_wreg, bus.out_funct3} !== {3'd4, 1'b0, 3'd2}) begin
      n_fail++; $display("FAIL sw_fields got %0h want %0h", {bus.out_class, bus.out_wreg, bus.out_funct3}, {3'd4, 1'b0, 3'd2}); end
    n_chk++; if ({bus.out_opa, bus.out_opb, bus.out_storedata} !== {32'h100, 32'hFFFFFFFC, 32'h55}) begin
      n_fail++; $display("FAIL sw_ops got %0h want %0h", {bus.out_opa, bus.out_opb, bus.out_storedata}, {32'h100, 32'hFFFFFFFC, 32'h55}); end
  endtask

  task automatic test_backpressure();
    idle(); bus.in_valid = 1; bus.in_inst = enc_i(32'h11, 0, 0, 9, 7'h13);
    tick();
    bus.out_ready = 0; bus.in_inst = enc_i(32'h22, 0, 0, 10, 7'h13);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d got %0h want 0", i, bus.in_ready); end
      n_chk++; if ({bus.out_valid, bus.out_rd, bus.out_opb} !== {1'b1, 5'd9, 32'h11}) begin
        n_fail++; $display("FAIL bp_hold%0d got %0h want %0h", i, {bus.out_valid, bus.out_rd, bus.out_opb}, {1'b1, 5'd9, 32'h11}); end
      tick();
    end
    bus.out_ready = 1;
    #1;
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept got %0h want 1", bus.in_ready); end
    tick(); idle();
    n_chk++; if ({bus.out_valid, bus.out_rd, bus.out_opb} !== {1'b1, 5'd10, 32'h22}) begin
      n_fail++; $display("FAIL bp_next got %0h want %0h", {bus.out_valid, bus.out_rd, bus.out_opb}, {1'b1, 5'd10, 32'h22}); end
  endtask

  task automatic test_flush();
    idle(); bus.in_valid = 1; bus.in_inst = enc_i(0, 0, 2, 12, 7'h03);
    tick();
    bus.flush = 1; bus.in_inst = enc_r(0, 0, 12, 0, 13);
    #1;
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_block got %0h want 0", bus.in_ready); end
    tick();
    bus.flush = 0;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid got %0h want 0", bus.out_valid); end
    #1;
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_still_stall got %0h want 0", bus.in_ready); end
    tick();
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_release got %0h want 1", bus.in_ready); end
    tick(); idle();
    n_chk++; if ({bus.out_valid, bus.out_rd} !== {1'b1, 5'd13}) begin
      n_fail++; $display("FAIL fl_dep got %0h want %0h", {bus.out_valid, bus.out_rd}, {1'b1, 5'd13}); end
  endtask

  task automatic test_reset_mid_stall();
    idle(); bus.in_valid = 1; bus.in_inst = enc_i(0, 0, 2, 14, 7'h03);
    tick();
    bus.in_inst = enc_r(0, 14, 14, 0, 15); bus.out_ready = 0;
    #1;
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rs_stall got %0h want 0", bus.in_ready); end
    rst = 1;
    tick();
    n_chk++; if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
      n_fail++; $display("FAIL rs_clear got %0h want 0", {bus.out_valid, bus.in_ready}); end
    rst = 0; bus.out_ready = 1;
    #1;
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rs_nohazard got %0h want 1", bus.in_ready); end
    tick(); idle();
    n_chk++; if ({bus.out_valid, bus.out_rd} !== {1'b1, 5'd15}) begin
      n_fail++; $display("FAIL rs_issue got %0h want %0h", {bus.out_valid, bus.out_rd}, {1'b1, 5'd15}); end
  endtask

  task automatic test_random();
    logic [6:0] ops [5];
    slot_t got;
    ops[0] = 7'h13; ops[1] = 7'h33; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h37;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins = $urandom();
      ins[6:0]   = ops[$urandom_range(4, 0)];
      ins[11:7]  = 5'($urandom_range(7, 0));
      ins[19:15] = 5'($urandom_range(7, 0));
      ins[24:20] = 5'($urandom_range(7, 0));
      bus.in_inst   = ins;
      bus.in_valid  = ($urandom_range(3, 0) != 0);
      bus.out_ready = ($urandom_range(3, 0) != 0);
      bus.flush     = ($urandom_range(19, 0) == 0);
      rst           = ($urandom_range(99, 0) == 0);
      bus.rdata1    = $urandom(); bus.rdata2 = $urandom();
      bus.fw_we     = 2'($urandom());
      bus.fw_addr   = {5'($urandom_range(7, 0)), 5'($urandom_range(7, 0))};
      bus.fw_data   = {32'($urandom()), 32'($urandom())};
      #1;
      n_chk++; if (bus.in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready@%0d got %0h want %0h", cyc, bus.in_ready, m_ready()); end
      n_chk++; if ({bus.raddr1, bus.raddr2} !== {ins[19:15], ins[24:20]}) begin
        n_fail++; $display("FAIL rnd_raddr@%0d got %0h want %0h", cyc, {bus.raddr1, bus.raddr2}, {ins[19:15], ins[24:20]}); end
      tick();
      rst = 0;
      n_chk++; if (bus.out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d got %0h want %0h", cyc, bus.out_valid, m_valid); end
      if (m_valid) begin
        got = {bus.out_class, bus.out_funct3, bus.out_funct7, bus.out_rd, bus.out_wreg, bus.out_opa, bus.out_opb, bus.out_storedata};
        n_chk++; if (got !== m_slot) begin n_fail++; $display("FAIL rnd_slot@%0d got %0h want %0h", cyc, got, m_slot); end
      end
    end
  endtask

  initial begin
    foreach (busy_until[i]) busy_until[i] = -1;
    rst = 1; bus.in_inst = '0;
    idle();
    test_reset();
    test_addi();
    test_forward_priority();
    test_load_use();
    test_store();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- XLEN, 32, datapath width
- NFWD, 2, number of forwarding sources (index 0 = youngest)
- LOAD_LAT, 2, cycles after load issue before its result appears on a forwarding source
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, rising-edge clock
- rst, in, 1, reset, synchronous, active-high
- in_valid, in, 1, instruction from IF/ID is valid
- in_inst, in, 32, RV32 instruction word
- in_ready, out, 1, instruction accepted this cycle
- flush, in, 1, discard the issued slot
- raddr1 / raddr2, out, 5, register-file read addresses (rs1 / rs2 fields)
- rdata1 / rdata2, in, XLEN, register-file read data, combinational
- fw_we, in, NFWD, per-source write-enable
- fw_addr, in, 5*NFWD, per-source destination register, source k at bits [5k+4:5k]
- fw_data, in, XLEN*NFWD, per-source data, source k at bits [XLEN*k+XLEN-1:XLEN*k]
- out_valid, out, 1, ID/EX slot holds an instruction
- out_ready, in, 1, EX accepts the slot
- out_class, out, 3, 0 NOP, 1 ALU_IMM, 2 ALU_REG, 3 LOAD, 4 STORE
- out_funct3, out, 3, funct3 field
- out_funct7, out, 7, funct7 field
- out_rd, out, 5, destination register
- out_wreg, out, 1, write-back enable
- out_opa / out_opb, out, XLEN, ALU operands
- out_storedata, out, XLEN, store data

Function
REQ-003 Decode: 0010011 -> ALU_IMM; 0110011 -> ALU_REG; 0000011 -> LOAD; 0100011 -> STORE; any other opcode -> NOP with out_wreg=0.
REQ-004 Immediates are sign-extended: I-type from inst[31:20]; S-type from {inst[31:25], inst[11:7]}.
REQ-005 Operand mapping by class:
- ALU_IMM and LOAD: opa=src(rs1), opb=I-imm
- ALU_REG: opa=src(rs1), opb=src(rs2)
- STORE: opa=src(rs1), opb=S-imm, storedata=src(rs2)
- NOP: opa=opb=0
- storedata=0 for every class other than STORE
REQ-006 src(r) resolution:
- r=0 -> 0, regardless of forwarding
- otherwise the lowest-index source k with fw_we[k]=1 and fw_addr[k]=r
- otherwise rdata for r
REQ-007 out_wreg=1 only for ALU_IMM, ALU_REG and LOAD with rd!=0.
REQ-008 Scoreboard: per-register counter cnt[1..31], 0..LOAD_LAT; cnt[0] is fixed at 0.
REQ-009 On issue of a LOAD with rd!=0, cnt[rd] loads LOAD_LAT.
REQ-010 Every cycle, each nonzero counter not being loaded decrements by 1; a load on the same register in the same cycle overrides the decrement.
REQ-011 hazard = in_valid and a register read by the decoded class (rs1 for all non-NOP classes; rs2 for ALU_REG and STORE) is nonzero with cnt!=0.
REQ-012 in_ready = !hazard and (!out_valid or out_ready) and !flush.
REQ-013 Issue = in_valid and in_ready. On issue, the slot registers all decoded fields and out_valid=1 at the next edge.
REQ-014 When out_valid=1 and out_ready=1 with no issue, out_valid=0 at the next edge.
REQ-015 When out_valid=1 and out_ready=0, every out_* holds stable.
REQ-016 flush=1 forces out_valid=0 at the next edge and blocks issue. The scoreboard is unaffected, since in-flight loads remain in flight.
REQ-017 Issue latency: one cycle from acceptance to out_valid. Throughput: one instruction per cycle when there is no hazard and out_ready=1.
REQ-018 raddr1 = inst[19:15] and raddr2 = inst[24:20], combinationally, at all times.

Reset
REQ-019 With rst=1 at a rising edge:
- out_valid=0, out_class=0, out_wreg=0
- out_rd, out_funct3, out_funct7, out_opa, out_opb, out_storedata = 0
- all cnt = 0
REQ-020 While rst=1, in_ready=0. rst overrides flush and issue in the same cycle.
REQ-021 rst asserted mid-stall drops the pending instruction and the slot; the first instruction accepted after release issues with no hazard.

Verification
REQ-022 addi x1,x0,5 (0x00500093), out_ready=1 -> next cycle: out_valid=1, class=1, rd=1, wreg=1, opa=0, opb=5.
REQ-023 add x3,x1,x2 with fw_we=2'b11, fw_addr0=1/data0=0xA, fw_addr1=1/data1=0xB, rdata2=7 -> opa=0xA (source 0 wins), opb=7.
REQ-024 lw x5,0(x4), then add x6,x5,x5, with LOAD_LAT=2 -> in_ready=0 for exactly 2 cycles; add issues on the third cycle with opa=opb=fw_data for x5.
REQ-025 sw x7,-4(x8) with rdata1=0x100, rdata2=0x55 -> class=4, wreg=0, opa=0x100, opb=0xFFFFFFFC, storedata=0x55.
REQ-026 Slot valid, out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 and outputs stable; the first cycle with out_ready=1 accepts the next instruction, which appears the cycle after.
REQ-027 Flush with slot valid -> out_valid=0 next cycle; a load issued before the flush still stalls its dependent for LOAD_LAT cycles. rst pulsed during a stall -> all cnt=0 and out_valid=0.
